// File: rtl/alu_load_sequencer.sv
// Operator-paced loader for a registered ALU: each debounced press of btn_load latches
// the switches into A, B, then the opcode, and finally triggers and captures one evaluation.
module alu_load_sequencer #(
  parameter int N_SWITCH        = 6,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ALU_LATENCY     = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [N_SWITCH-1:0] switches,
  input  logic                btn_load,
  input  logic                btn_clear,
  input  logic [N_SWITCH-1:0] alu_result,
  output logic [N_SWITCH-1:0] data_a,
  output logic [N_SWITCH-1:0] data_b,
  output logic [N_SWITCH-1:0] op,
  output logic                alu_start,
  output logic [N_SWITCH-1:0] result_leds,
  output logic [1:0]          step,
  output logic                busy
);

  // state   | meaning
  // LOAD_A  | next load press latches switches into data_a
  // LOAD_B  | next load press latches switches into data_b
  // LOAD_OP | next load press latches switches into op and starts the ALU
  // SHOW    | waiting for / displaying the captured result
  localparam logic [1:0] LOAD_A  = 2'd0;
  localparam logic [1:0] LOAD_B  = 2'd1;
  localparam logic [1:0] LOAD_OP = 2'd2;
  localparam logic [1:0] SHOW    = 2'd3;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(ALU_LATENCY + 1);

  // bit 0 = load button, bit 1 = clear button
  logic [1:0]    btn_raw;
  logic [1:0]    sync_1;
  logic [1:0]    sync_2;
  logic [1:0]    deb;
  logic [1:0]    deb_q;
  logic [DW-1:0] db_cnt [2];
  logic          load_evt;
  logic          clear_evt;
  logic [1:0]    state;
  logic [LW-1:0] lat_cnt;

  assign btn_raw = {btn_clear, btn_load};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
      deb    <= '0;
      deb_q  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      deb_q  <= deb;
      // Any cycle where the synchronized level agrees with the debounced one restarts the count.
      for (int i = 0; i < 2; i++) begin
        if (sync_2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]    <= sync_2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign load_evt  = deb[0] & ~deb_q[0];
  assign clear_evt = deb[1] & ~deb_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= LOAD_A;
      data_a      <= '0;
      data_b      <= '0;
      op          <= '0;
      result_leds <= '0;
      alu_start   <= 1'b0;
      busy        <= 1'b0;
      lat_cnt     <= '0;
    end else begin
      alu_start <= 1'b0;
      // Clear outranks everything, including a load press landing on the same cycle.
      if (clear_evt) begin
        state   <= LOAD_A;
        busy    <= 1'b0;
        lat_cnt <= '0;
      end else begin
        if (busy) begin
          if (lat_cnt == '0) begin
            result_leds <= alu_result;
            busy        <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        if (load_evt) begin
          case (state)
            LOAD_A: begin
              data_a <= switches;
              state  <= LOAD_B;
            end
            LOAD_B: begin
              data_b <= switches;
              state  <= LOAD_OP;
            end
            LOAD_OP: begin
              op        <= switches;
              state     <= SHOW;
              alu_start <= 1'b1;
              busy      <= 1'b1;
              lat_cnt   <= LW'(ALU_LATENCY - 1);
            end
            default: begin
              if (!busy) state <= LOAD_A;
            end
          endcase
        end
      end
    end
  end

  assign step = state;

endmodule

// File: tb/tb_alu_load_sequencer.sv
// Bench for alu_load_sequencer: a fast (latency 1) and a slow (latency 20) instance share
// the button/switch stimulus; each is compared against an event-level model of the sequencer.
module tb_alu_load_sequencer;
  localparam int N  = 6;
  localparam int D  = 4;
  localparam int L0 = 1;
  localparam int L1 = 20;
  localparam int H  = 12;

  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         btn_load = 1'b0;
  logic         btn_clear = 1'b0;
  logic [N-1:0] switches = '0;
  logic [N-1:0] alu_res [2];
  logic [N-1:0] data_a [2];
  logic [N-1:0] data_b [2];
  logic [N-1:0] op [2];
  logic [N-1:0] leds [2];
  logic         alu_start [2];
  logic         busy [2];
  logic [1:0]   step [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int starts [2] = '{0, 0};
  int busy_cyc [2] = '{0, 0};

  // model state
  int         lat [2] = '{L0, L1};
  logic [5:0] m_a [2], m_b [2], m_op [2], m_res [2], m_pend [2];
  logic [1:0] m_step [2];
  bit         m_pending [2];
  int         m_c [2];
  int         m_starts [2] = '{0, 0};
  int         m_busycyc [2] = '{0, 0};

  function automatic logic [5:0] alu_f(input logic [5:0] a, input logic [5:0] b, input logic [5:0] o);
    case (o)
      6'h20:   return a + b;
      6'h21:   return a - b;
      default: return a ^ b;
    endcase
  endfunction

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign alu_res[0] = alu_f(data_a[0], data_b[0], op[0]);
  logic [N-1:0] pipe [L1-1];
  always @(posedge clock) begin
    pipe[0] <= alu_f(data_a[1], data_b[1], op[1]);
    for (int k = 1; k < L1 - 1; k++) pipe[k] <= pipe[k-1];
  end
  assign alu_res[1] = pipe[L1-2];

  always @(negedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        starts[i]   += int'(alu_start[i]);
        busy_cyc[i] += int'(busy[i]);
      end
    end
  end

  alu_load_sequencer #(.N_SWITCH(N), .DEBOUNCE_CYCLES(D), .ALU_LATENCY(L0)) u_fast (
    .clock(clock), .reset_n(reset_n), .switches(switches), .btn_load(btn_load),
    .btn_clear(btn_clear), .alu_result(alu_res[0]), .data_a(data_a[0]), .data_b(data_b[0]),
    .op(op[0]), .alu_start(alu_start[0]), .result_leds(leds[0]), .step(step[0]), .busy(busy[0]));

  alu_load_sequencer #(.N_SWITCH(N), .DEBOUNCE_CYCLES(D), .ALU_LATENCY(L1)) u_slow (
    .clock(clock), .reset_n(reset_n), .switches(switches), .btn_load(btn_load),
    .btn_clear(btn_clear), .alu_result(alu_res[1]), .data_a(data_a[1]), .data_b(data_b[1]),
    .op(op[1]), .alu_start(alu_start[1]), .result_leds(leds[1]), .step(step[1]), .busy(busy[1]));

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_a[i] = '0; m_b[i] = '0; m_op[i] = '0; m_res[i] = '0; m_pend[i] = '0;
      m_step[i] = 2'd0; m_pending[i] = 1'b0; m_c[i] = 0;
    end
  endfunction

  // A result is captured at the end of cycle (op event cycle + latency).
  function automatic void m_advance(input int i, input int x);
    if (m_pending[i] && (m_c[i] + lat[i] < x)) begin
      m_res[i] = m_pend[i];
      m_pending[i] = 1'b0;
    end
  endfunction

  // Apply a button event occurring in cycle x.
  function automatic void m_event(input int x, input bit ld, input bit clr, input logic [5:0] sw);
    for (int i = 0; i < 2; i++) begin
      m_advance(i, x);
      if (clr) begin
        if (m_pending[i]) m_busycyc[i] -= m_c[i] + lat[i] - x;
        m_pending[i] = 1'b0;
        m_step[i] = 2'd0;
      end else if (ld) begin
        case (m_step[i])
          2'd0: begin m_a[i] = sw; m_step[i] = 2'd1; end
          2'd1: begin m_b[i] = sw; m_step[i] = 2'd2; end
          2'd2: begin
            m_op[i] = sw; m_step[i] = 2'd3; m_pending[i] = 1'b1; m_c[i] = x;
            m_pend[i] = alu_f(m_a[i], m_b[i], sw);
            m_starts[i]++; m_busycyc[i] += lat[i];
          end
          default: if (!m_pending[i]) m_step[i] = 2'd0;
        endcase
      end
    end
  endfunction

  // Raw edge in cycle n gives the event in cycle n+D+2.
  task automatic press(input bit ld, input bit clr, input logic [5:0] sw);
    @(negedge clock);
    switches = sw; btn_load = ld; btn_clear = clr;
    m_event(cyc + D + 2, ld, clr, sw);
    repeat (H) @(negedge clock);
    btn_load = 1'b0; btn_clear = 1'b0;
    repeat (H) @(negedge clock);
  endtask

  task automatic test_reset(input bit preload);
    logic eb;
    if (preload) begin
      press(1'b1, 1'b0, 6'($urandom));
      press(1'b1, 1'b0, 6'($urandom));
    end
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({data_a[i], data_b[i], op[i], leds[i], step[i], busy[i], alu_start[i]} !== '0) begin
        n_err++;
        $display("FAIL reset_async dut%0d: outputs a=%h b=%h op=%h leds=%h step=%0d busy=%0b start=%0b, want all 0",
                 i, data_a[i], data_b[i], op[i], leds[i], step[i], busy[i], alu_start[i]);
      end
    end
    m_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      m_advance(i, cyc);
      eb = m_pending[i] && (cyc > m_c[i]);
      n_vec++;
      if ({data_a[i], data_b[i], op[i], leds[i], step[i], busy[i]} !== {m_a[i], m_b[i], m_op[i], m_res[i], m_step[i], eb}) begin
        n_err++;
        $display("FAIL reset_release dut%0d: a/b/op/leds/step/busy got %h %h %h %h %0d %0b want %h %h %h %h %0d %0b",
                 i, data_a[i], data_b[i], op[i], leds[i], step[i], busy[i], m_a[i], m_b[i], m_op[i], m_res[i], m_step[i], eb);
      end
    end
  endtask

  task automatic test_load_seq();
    int n, t, s0, b0;
    logic eb;
    s0 = starts[0]; b0 = busy_cyc[0];
    @(negedge clock);
    switches = 6'h05; btn_load = 1'b1; n = cyc;
    m_event(n + D + 2, 1'b1, 1'b0, 6'h05);
    for (int k = 0; k < 40 && step[0] == 2'd0; k++) @(negedge clock);
    t = cyc;
    n_vec++;
    if (t != n + D + 3) begin
      n_err++;
      $display("FAIL event_latency: step changed at cycle offset %0d, want %0d", t - n, D + 3);
    end
    while (cyc < n + H) @(negedge clock);
    btn_load = 1'b0;
    repeat (H) @(negedge clock);
    press(1'b1, 1'b0, 6'h03);
    @(negedge clock);
    switches = 6'h20; btn_load = 1'b1; n = cyc;
    m_event(n + D + 2, 1'b1, 1'b0, 6'h20);
    for (int k = 0; k < 40 && alu_start[0] !== 1'b1; k++) @(negedge clock);
    n_vec++;
    if (cyc != n + D + 3 || busy[0] !== 1'b1 || step[0] !== 2'd3) begin
      n_err++;
      $display("FAIL start_pulse: start at offset %0d busy=%0b step=%0d, want offset %0d busy=1 step=3",
               cyc - n, busy[0], step[0], D + 3);
    end
    @(negedge clock);
    n_vec++;
    if (leds[0] !== 6'h08 || busy[0] !== 1'b0 || alu_start[0] !== 1'b0) begin
      n_err++;
      $display("FAIL capture_next_cycle: leds=%h busy=%0b start=%0b, want leds=08 busy=0 start=0",
               leds[0], busy[0], alu_start[0]);
    end
    while (cyc < n + H) @(negedge clock);
    btn_load = 1'b0;
    repeat (H) @(negedge clock);
    n_vec++;
    if (starts[0] - s0 != 1 || busy_cyc[0] - b0 != L0) begin
      n_err++;
      $display("FAIL single_start: starts=%0d busy_cycles=%0d, want 1 and %0d", starts[0] - s0, busy_cyc[0] - b0, L0);
    end
    for (int r = 0; r < 8; r++) begin
      press(1'b1, 1'b0, (r % 3 == 2) ? 6'h20 + 6'($urandom_range(0, 1)) : 6'($urandom));
      for (int i = 0; i < 2; i++) begin
        m_advance(i, cyc);
        eb = m_pending[i] && (cyc > m_c[i]);
        n_vec++;
        if ({data_a[i], data_b[i], op[i], leds[i], step[i], busy[i]} !== {m_a[i], m_b[i], m_op[i], m_res[i], m_step[i], eb}) begin
          n_err++;
          $display("FAIL random_seq r%0d dut%0d: a/b/op/leds/step/busy got %h %h %h %h %0d %0b want %h %h %h %h %0d %0b",
                   r, i, data_a[i], data_b[i], op[i], leds[i], step[i], busy[i], m_a[i], m_b[i], m_op[i], m_res[i], m_step[i], eb);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int n;
    logic [5:0] sw;
    logic eb;
    press(1'b0, 1'b1, '0);
    sw = 6'($urandom);
    @(negedge clock);
    switches = sw;
    for (int k = 0; k < 10; k++) begin
      btn_load = (k % 2 == 0);
      @(negedge clock);
    end
    btn_load = 1'b1; n = cyc;
    m_event(n + D + 2, 1'b1, 1'b0, sw);
    repeat (20) @(negedge clock);
    btn_load = 1'b0;
    repeat (H) @(negedge clock);
    btn_load = 1'b1;
    repeat (3) @(negedge clock);
    btn_load = 1'b0;
    repeat (2 * H) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      m_advance(i, cyc);
      eb = m_pending[i] && (cyc > m_c[i]);
      n_vec++;
      if ({data_a[i], data_b[i], op[i], leds[i], step[i], busy[i]} !== {m_a[i], m_b[i], m_op[i], m_res[i], m_step[i], eb}) begin
        n_err++;
        $display("FAIL bounce_glitch dut%0d: a/b/op/leds/step/busy got %h %h %h %h %0d %0b want %h %h %h %h %0d %0b",
                 i, data_a[i], data_b[i], op[i], leds[i], step[i], busy[i], m_a[i], m_b[i], m_op[i], m_res[i], m_step[i], eb);
      end
    end
  endtask

  task automatic test_clear_load_tie();
    int s0;
    logic [5:0] op_old;
    press(1'b1, 1'b0, 6'($urandom));
    press(1'b1, 1'b0, 6'($urandom));
    s0 = starts[0];
    op_old = op[0];
    press(1'b1, 1'b1, 6'($urandom));
    n_vec++;
    if (step[0] !== m_step[0] || op[0] !== m_op[0] || starts[0] != m_starts[0] || starts[0] != s0) begin
      n_err++;
      $display("FAIL clear_load_tie: step=%0d op=%h starts=%0d, want step=%0d op=%h starts=%0d (op before %h)",
               step[0], op[0], starts[0], m_step[0], m_op[0], m_starts[0], op_old);
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    logic eb;
    press(1'b0, 1'b1, '0);
    press(1'b1, 1'b0, 6'($urandom));
    press(1'b1, 1'b0, 6'($urandom));
    @(negedge clock);
    switches = 6'h20; btn_load = 1'b1; n = cyc;
    m_event(n + D + 2, 1'b1, 1'b0, 6'h20);
    while (cyc < n + 8) @(negedge clock);
    btn_load = 1'b0;
    while (cyc < n + 14) @(negedge clock);
    switches = 6'($urandom); btn_load = 1'b1;
    m_event(n + 14 + D + 2, 1'b1, 1'b0, switches);
    while (cyc < n + 23) @(negedge clock);
    n_vec++;
    if (step[1] !== 2'd3 || busy[1] !== 1'b1) begin
      n_err++;
      $display("FAIL load_while_busy: step=%0d busy=%0b, want step=3 busy=1", step[1], busy[1]);
    end
    while (cyc < n + 30) @(negedge clock);
    btn_load = 1'b0;
    repeat (H) @(negedge clock);
    press(1'b1, 1'b0, 6'($urandom));
    for (int i = 0; i < 2; i++) begin
      m_advance(i, cyc);
      eb = m_pending[i] && (cyc > m_c[i]);
      n_vec++;
      if ({data_a[i], data_b[i], op[i], leds[i], step[i], busy[i]} !== {m_a[i], m_b[i], m_op[i], m_res[i], m_step[i], eb}) begin
        n_err++;
        $display("FAIL load_after_capture dut%0d: a/b/op/leds/step/busy got %h %h %h %h %0d %0b want %h %h %h %h %0d %0b",
                 i, data_a[i], data_b[i], op[i], leds[i], step[i], busy[i], m_a[i], m_b[i], m_op[i], m_res[i], m_step[i], eb);
      end
    end
  endtask

  task automatic test_clear_during_busy();
    int n;
    logic [5:0] a, b, old_leds;
    logic eb;
    press(1'b0, 1'b1, '0);
    do begin
      a = 6'($urandom); b = 6'($urandom);
    end while (alu_f(a, b, 6'h20) == m_res[1]);
    press(1'b1, 1'b0, a);
    press(1'b1, 1'b0, b);
    old_leds = leds[1];
    @(negedge clock);
    switches = 6'h20; btn_load = 1'b1; n = cyc;
    m_event(n + D + 2, 1'b1, 1'b0, 6'h20);
    while (cyc < n + 8) @(negedge clock);
    btn_load = 1'b0; btn_clear = 1'b1;
    m_event(n + 8 + D + 2, 1'b0, 1'b1, '0);
    while (cyc < n + 20) @(negedge clock);
    btn_clear = 1'b0;
    while (cyc < n + 40) @(negedge clock);
    n_vec++;
    if (leds[1] !== old_leds || step[1] !== 2'd0 || busy[1] !== 1'b0) begin
      n_err++;
      $display("FAIL clear_during_busy: leds=%h step=%0d busy=%0b, want leds=%h step=0 busy=0", leds[1], step[1], busy[1], old_leds);
    end
    for (int i = 0; i < 2; i++) begin
      m_advance(i, cyc);
      eb = m_pending[i] && (cyc > m_c[i]);
      n_vec++;
      if ({data_a[i], data_b[i], op[i], leds[i], step[i], busy[i]} !== {m_a[i], m_b[i], m_op[i], m_res[i], m_step[i], eb}) begin
        n_err++;
        $display("FAIL clear_busy_state dut%0d: a/b/op/leds/step/busy got %h %h %h %h %0d %0b want %h %h %h %h %0d %0b",
                 i, data_a[i], data_b[i], op[i], leds[i], step[i], busy[i], m_a[i], m_b[i], m_op[i], m_res[i], m_step[i], eb);
      end
      n_vec++;
      if (starts[i] != m_starts[i] || busy_cyc[i] != m_busycyc[i]) begin
        n_err++;
        $display("FAIL start_busy_totals dut%0d: starts=%0d busy_cycles=%0d, want %0d and %0d",
                 i, starts[i], busy_cyc[i], m_starts[i], m_busycyc[i]);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset(1'b0);
    test_load_seq();
    test_bounce();
    test_clear_load_tie();
    test_busy_ignore();
    test_clear_during_busy();
    test_reset(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", n_vec);
    $fatal(1, "timeout");
  end

endmodule
